// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial_loader parallel-to-serial front end.
package serial_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Bit-counter width for a word of `width` bits; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_loader_if.sv
// Valid/ready word handshake into the serial_loader.
interface serial_loader_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/serial_loader.sv
// Buffers one WIDTH-bit word and streams words gaplessly, one bit per clock,
// on ser_out/ser_en for a downstream serial-input shift stage.
module serial_loader
    import serial_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    serial_loader_if.slave  bus,
    output logic            ser_out,
    output logic            ser_en,
    output logic            busy,
    output logic            done
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t            state;
    logic [WIDTH-1:0]  hold;
    logic              hold_full;
    logic [WIDTH-1:0]  sreg;
    logic [CW-1:0]     cnt;
    logic              done_q;
    logic              accept;
    logic [WIDTH-1:0]  sreg_next;

    assign bus.data_ready = !hold_full && !rst;
    assign accept         = bus.data_valid && bus.data_ready;

    // Shift toward whichever end is currently driving ser_out.
    assign sreg_next = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                                 : {1'b0, sreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            hold_full <= 1'b0;
            sreg      <= '0;
            cnt       <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // NOTE: hold carries data only and is qualified by hold_full, so it is not reset.
            if (accept) begin
                hold      <= bus.data_in;
                hold_full <= 1'b1;
            end

            // accept needs an empty hold and every transfer needs a full one,
            // so the set and clear of hold_full never collide.
            case (state)
                ST_IDLE: begin
                    if (hold_full) begin
                        sreg      <= hold;
                        cnt       <= '0;
                        hold_full <= 1'b0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == LAST) begin
                        done_q <= 1'b1;
                        if (hold_full) begin
                            sreg      <= hold;
                            cnt       <= '0;
                            hold_full <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        sreg <= sreg_next;
                        cnt  <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ser_en  = (state == ST_SHIFT);
    assign ser_out = ser_en && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
    assign busy    = (state == ST_SHIFT) || hold_full;
    assign done    = done_q;

endmodule
